run_controller: RTL



---
 rtl/run_controller.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/run_controller.sv
// Run controller for the RISC-V core: holds the core in reset, releases it,
// counts cycles and retired instructions, and latches pass/fail/timeout status.
module run_controller #(
    parameter int RESET_CYCLES = 5,
    parameter int MAX_CYCLES   = 1000,
    parameter int CNT_WIDTH    = 32,
    parameter int CODE_WIDTH   = 8,
    parameter int PASS_CODE    = 0,
    parameter bit AUTO_START   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  retire,
    input  logic                  halt_valid,
    input  logic [CODE_WIDTH-1:0] halt_code,
    output logic                  cpu_reset,
    output logic                  running,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [CNT_WIDTH-1:0]  cycle_count,
    output logic [CNT_WIDTH-1:0]  instret_count,
    output logic [CODE_WIDTH-1:0] last_code
);

    localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
    // Counter value seen on the edge that completes MAX_CYCLES run edges.
    localparam logic [63:0]          LIMIT_M1  = 64'(MAX_CYCLES) - 64'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [HOLD_W-1:0]     r_hold_cnt;
    logic                  r_cpu_reset;
    logic                  r_running;
    logic                  r_done;
    logic                  r_pass;
    logic                  r_timeout;
    logic [CNT_WIDTH-1:0]  r_cycle_count;
    logic [CNT_WIDTH-1:0]  r_instret_count;
    logic [CODE_WIDTH-1:0] r_last_code;

    logic                  w_clear;
    logic                  w_count;
    logic                  w_halt_end;
    logic                  w_timeout_end;
    logic                  w_limit_hit;
    logic [CNT_WIDTH-1:0]  w_cycle_inc;
    logic [CNT_WIDTH-1:0]  w_instret_inc;

    assign w_limit_hit   = (MAX_CYCLES != 0) && (64'(r_cycle_count) == LIMIT_M1);
    assign w_cycle_inc   = (r_cycle_count == CNT_MAX) ? r_cycle_count
                                                      : r_cycle_count + CNT_WIDTH'(1);
    assign w_instret_inc = (r_instret_count == CNT_MAX) ? r_instret_count
                                                        : r_instret_count + CNT_WIDTH'(1);

    // Next-state decode and per-edge action strobes.
    always_comb begin
        w_state_next  = r_state;
        w_clear       = 1'b0;
        w_count       = 1'b0;
        w_halt_end    = 1'b0;
        w_timeout_end = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start || AUTO_START) begin
                    w_state_next = ST_HOLD;
                    w_clear      = 1'b1;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (r_hold_cnt == HOLD_LAST) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_HOLD;
                end
            end
            ST_RUN: begin
                w_count = 1'b1;
                if (halt_valid) begin
                    w_state_next = ST_DONE;
                    w_halt_end   = 1'b1;
                end else if (w_limit_hit) begin
                    w_state_next  = ST_DONE;
                    w_timeout_end = 1'b1;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            ST_DONE: begin
                // Only an explicit start re-arms from DONE; AUTO_START does not.
                if (start) begin
                    w_state_next = ST_HOLD;
                    w_clear      = 1'b1;
                end else begin
                    w_state_next = ST_DONE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register, registered outputs, counters and status capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_hold_cnt      <= '0;
            r_cpu_reset     <= 1'b1;
            r_running       <= 1'b0;
            r_done          <= 1'b0;
            r_pass          <= 1'b0;
            r_timeout       <= 1'b0;
            r_cycle_count   <= '0;
            r_instret_count <= '0;
            r_last_code     <= '0;
        end else begin
            r_state     <= w_state_next;
            r_cpu_reset <= (w_state_next != ST_RUN);
            r_running   <= (w_state_next == ST_RUN);
            r_done      <= (w_state_next == ST_DONE);
            if (w_clear) begin
                r_hold_cnt      <= '0;
                r_pass          <= 1'b0;
                r_timeout       <= 1'b0;
                r_cycle_count   <= '0;
                r_instret_count <= '0;
                r_last_code     <= '0;
            end else begin
                if (r_state == ST_HOLD) begin
                    r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                end
                if (w_count) begin
                    r_cycle_count <= w_cycle_inc;
                    if (retire) begin
                        r_instret_count <= w_instret_inc;
                    end
                end
                if (w_halt_end) begin
                    r_last_code <= halt_code;
                    r_pass      <= (halt_code == CODE_WIDTH'(PASS_CODE));
                    r_timeout   <= 1'b0;
                end else if (w_timeout_end) begin
                    r_last_code <= '0;
                    r_pass      <= 1'b0;
                    r_timeout   <= 1'b1;
                end
            end
        end
    end

    assign cpu_reset     = r_cpu_reset;
    assign running       = r_running;
    assign done          = r_done;
    assign pass          = r_pass;
    assign timeout       = r_timeout;
    assign cycle_count   = r_cycle_count;
    assign instret_count = r_instret_count;
    assign last_code     = r_last_code;

endmodule
